// File: rtl/muldiv_if.sv
// muldiv_if: request/response bundle between the execute stage and the
// multi-cycle RV32M sequencer.
//   start_i  : request strobe, accepted when ready_o && start_i && !kill_i
//   op_i     : alu_ops_e code (5 bits), sampled at accept
//   a_i/b_i  : rs1 / rs2 operands, sampled at accept
//   kill_i   : pipeline flush, aborts any in-flight operation
//   ready_o  : sequencer idle and able to accept
//   done_o   : one-cycle pulse, result_o valid in that cycle
//   result_o : last result, held until the next done_o
// master = execute stage side, slave = sequencer side.
interface muldiv_if #(
  parameter int XLEN = 32
);
  logic            start_i;
  logic [4:0]      op_i;
  logic [XLEN-1:0] a_i;
  logic [XLEN-1:0] b_i;
  logic            kill_i;
  logic            ready_o;
  logic            done_o;
  logic [XLEN-1:0] result_o;

  modport master (
    output start_i, op_i, a_i, b_i, kill_i,
    input  ready_o, done_o, result_o
  );

  modport slave (
    input  start_i, op_i, a_i, b_i, kill_i,
    output ready_o, done_o, result_o
  );
endinterface

// File: rtl/muldiv_seq.sv
// muldiv_seq: multi-cycle sequencer for RV32M (MUL..REMU).
// Runs a 32-iteration shift-add multiply or restoring divide on operand
// magnitudes, applies sign fix-up and returns one registered result.
// Divide-by-zero and signed overflow are resolved at accept and skip the
// iteration phase.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : muldiv_if.slave (start/op/a/b/kill in, ready/done/result out)
module muldiv_seq #(
  parameter int XLEN = 32
) (
  input  logic     clk,
  input  logic     rst,
  muldiv_if.slave  bus
);

  localparam logic [4:0] OP_MUL    = 5'b01110;
  localparam logic [4:0] OP_MULH   = 5'b01111;
  localparam logic [4:0] OP_MULHSU = 5'b10000;
  localparam logic [4:0] OP_MULHU  = 5'b10001;
  localparam logic [4:0] OP_DIV    = 5'b10010;
  localparam logic [4:0] OP_DIVU   = 5'b10011;
  localparam logic [4:0] OP_REM    = 5'b10100;
  localparam logic [4:0] OP_REMU   = 5'b10101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e r_state;
  state_e w_state_nxt;

  logic [4:0]        r_op;
  logic              r_sign;
  logic [5:0]        r_cnt;
  logic [XLEN-1:0]   r_opnd;    // multiplicand (mul) or divisor (div) magnitude
  logic [2*XLEN-1:0] r_acc;     // mul: product:multiplier, div: remainder:quotient
  logic [XLEN-1:0]   r_result;

  // Accept-time decode
  logic            w_legal;
  logic            w_accept;
  logic            w_is_div;
  logic            w_signed_a;
  logic            w_signed_b;
  logic            w_neg_a;
  logic            w_neg_b;
  logic [XLEN-1:0] w_abs_a;
  logic [XLEN-1:0] w_abs_b;
  logic            w_sign;
  logic            w_div0;
  logic            w_ovf;
  logic            w_special;
  logic [XLEN-1:0] w_special_res;

  // Iteration and fix-up datapath
  logic            r_is_div;
  logic [XLEN:0]   w_mul_sum;
  logic [XLEN:0]   w_rem_sh;
  logic [XLEN:0]   w_diff;
  logic [2*XLEN-1:0] w_acc_nxt;
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0] w_quo;
  logic [XLEN-1:0] w_rem;
  logic [XLEN-1:0] w_fix_res;

  // ---------------------------------------------------------------------
  // Accept decode
  // ---------------------------------------------------------------------
  always_comb begin
    w_legal    = (bus.op_i >= OP_MUL) && (bus.op_i <= OP_REMU);
    w_accept   = (r_state == S_IDLE) && bus.start_i && !bus.kill_i && w_legal;
    w_is_div   = (bus.op_i >= OP_DIV);
    w_signed_a = (bus.op_i == OP_MULH) || (bus.op_i == OP_MULHSU) ||
                 (bus.op_i == OP_DIV)  || (bus.op_i == OP_REM);
    w_signed_b = (bus.op_i == OP_MULH) || (bus.op_i == OP_DIV) || (bus.op_i == OP_REM);
    w_neg_a    = w_signed_a && bus.a_i[XLEN-1];
    w_neg_b    = w_signed_b && bus.b_i[XLEN-1];
    // Negating 0x8000_0000 yields 0x8000_0000, which read unsigned is 2^31.
    w_abs_a    = w_neg_a ? -bus.a_i : bus.a_i;
    w_abs_b    = w_neg_b ? -bus.b_i : bus.b_i;
    // Remainder takes the dividend's sign; quotient and products take a^b.
    w_sign     = (bus.op_i == OP_REM) ? w_neg_a : (w_neg_a ^ w_neg_b);

    w_div0     = w_is_div && (bus.b_i == '0);
    w_ovf      = ((bus.op_i == OP_DIV) || (bus.op_i == OP_REM)) &&
                 (bus.a_i == {1'b1, {(XLEN-1){1'b0}}}) && (bus.b_i == '1);
    w_special  = w_div0 || w_ovf;

    w_special_res = '0;
    if (w_div0) begin
      w_special_res = ((bus.op_i == OP_DIV) || (bus.op_i == OP_DIVU)) ? '1 : bus.a_i;
    end else if (w_ovf) begin
      w_special_res = (bus.op_i == OP_DIV) ? bus.a_i : '0;
    end
  end

  // ---------------------------------------------------------------------
  // One iteration step and the fix-up result
  // ---------------------------------------------------------------------
  always_comb begin
    r_is_div  = (r_op >= OP_DIV);

    // Multiply: conditionally add multiplicand into the upper half, shift right.
    w_mul_sum = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_opnd} : '0);

    // Divide: the shifted remainder can reach 33 bits when the divisor is
    // above 2^31, so the trial subtract keeps that extra bit; diff[XLEN]
    // set means the subtraction borrowed.
    w_rem_sh  = r_acc[2*XLEN-1:XLEN-1];
    w_diff    = w_rem_sh - {1'b0, r_opnd};

    if (r_is_div) begin
      if (!w_diff[XLEN]) begin
        w_acc_nxt = {w_diff[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
      end else begin
        w_acc_nxt = {w_rem_sh[XLEN-1:0], r_acc[XLEN-2:0], 1'b0};
      end
    end else begin
      w_acc_nxt = {w_mul_sum, r_acc[XLEN-1:1]};
    end

    w_prod = r_sign ? -r_acc : r_acc;
    w_quo  = r_sign ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
    w_rem  = r_sign ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];

    case (r_op)
      OP_MUL:                        w_fix_res = w_prod[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  w_fix_res = w_prod[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:               w_fix_res = w_quo;
      default:                       w_fix_res = w_rem;
    endcase
  end

  // ---------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // NOTE: next-state is defaulted first so no path through the case can
  // leave it unassigned and infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) w_state_nxt = w_special ? S_DONE : S_CALC;
      end
      S_CALC: begin
        if (bus.kill_i)          w_state_nxt = S_IDLE;
        else if (r_cnt == 6'd31) w_state_nxt = S_FIX;
      end
      S_FIX: begin
        w_state_nxt = bus.kill_i ? S_IDLE : S_DONE;
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------
  // NOTE: the working registers are reset alongside result_o so a reset
  // leaves no stale operand or counter state behind.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op     <= '0;
      r_sign   <= 1'b0;
      r_cnt    <= '0;
      r_opnd   <= '0;
      r_acc    <= '0;
      r_result <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op   <= bus.op_i;
            r_sign <= w_sign;
            r_cnt  <= '0;
            if (w_is_div) begin
              r_opnd <= w_abs_b;
              r_acc  <= {{XLEN{1'b0}}, w_abs_a};
            end else begin
              r_opnd <= w_abs_a;
              r_acc  <= {{XLEN{1'b0}}, w_abs_b};
            end
            if (w_special) r_result <= w_special_res;
          end
        end
        S_CALC: begin
          r_acc <= w_acc_nxt;
          r_cnt <= r_cnt + 6'd1;
        end
        S_FIX: begin
          if (!bus.kill_i) r_result <= w_fix_res;
        end
        default: ;
      endcase
    end
  end

  assign bus.ready_o  = (r_state == S_IDLE);
  assign bus.done_o   = (r_state == S_DONE) && !bus.kill_i;
  assign bus.result_o = r_result;

endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: self-checking bench for muldiv_seq. Randomized and directed
// operations are compared against a plain-arithmetic reference model.
module tb_muldiv_seq;

  localparam logic [4:0] OP_ADD    = 5'b00000;
  localparam logic [4:0] OP_MUL    = 5'b01110;
  localparam logic [4:0] OP_MULH   = 5'b01111;
  localparam logic [4:0] OP_MULHSU = 5'b10000;
  localparam logic [4:0] OP_MULHU  = 5'b10001;
  localparam logic [4:0] OP_DIV    = 5'b10010;
  localparam logic [4:0] OP_DIVU   = 5'b10011;
  localparam logic [4:0] OP_REM    = 5'b10100;
  localparam logic [4:0] OP_REMU   = 5'b10101;

  logic clk;
  logic rst;
  int   n_pass;
  int   n_total;

  muldiv_if #(.XLEN(32)) u_if ();

  muldiv_seq #(.XLEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: straight 64-bit arithmetic on the architectural values.
  function automatic logic [31:0] ref_result(logic [4:0] op, logic [31:0] a, logic [31:0] b);
    longint     sa;
    longint     sb;
    longint     ub;
    longint     p;
    logic [63:0] up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'b0, b});
    case (op)
      OP_MUL:    begin p = sa * sb; return p[31:0];  end
      OP_MULH:   begin p = sa * sb; return p[63:32]; end
      OP_MULHSU: begin p = sa * ub; return p[63:32]; end
      OP_MULHU:  begin up = {32'b0, a} * {32'b0, b}; return up[63:32]; end
      OP_DIV:    begin if (b == 0) return 32'hFFFF_FFFF; p = sa / sb; return p[31:0]; end
      OP_DIVU:   begin if (b == 0) return 32'hFFFF_FFFF; return a / b; end
      OP_REM:    begin if (b == 0) return a; p = sa % sb; return p[31:0]; end
      default:   begin if (b == 0) return a; return a % b; end
    endcase
  endfunction

  function automatic int ref_latency(logic [4:0] op, logic [31:0] a, logic [31:0] b);
    bit is_div;
    bit ovf;
    is_div = (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
    ovf    = ((op == OP_DIV) || (op == OP_REM)) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    if (is_div && ((b == 0) || ovf)) return 1;
    return 34;
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'h0000_0001;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      5:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Issue one operation from a negedge, wait for done_o, report result and
  // latency (negedges from the drive point to the first one with done_o high).
  task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat, output bit timed_out);
    int guard;
    guard = 0;
    while (!u_if.ready_o && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    u_if.start_i = 1'b1;
    u_if.op_i    = op;
    u_if.a_i     = a;
    u_if.b_i     = b;
    lat       = 0;
    timed_out = 1'b1;
    res       = '0;
    while (lat < 60) begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        u_if.start_i = 1'b0;
        // Operands must be ignored once accepted.
        u_if.op_i = 5'($urandom_range(0, 31));
        u_if.a_i  = $urandom;
        u_if.b_i  = $urandom;
      end
      if (u_if.done_o === 1'b1) begin
        res       = u_if.result_o;
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic check_op(input string name, input logic [4:0] op,
                          input logic [31:0] a, input logic [31:0] b);
    logic [31:0] res;
    logic [31:0] exp_res;
    int          lat;
    int          exp_lat;
    bit          to;
    exp_res = ref_result(op, a, b);
    exp_lat = ref_latency(op, a, b);
    run_op(op, a, b, res, lat, to);
    n_total++;
    if (to) begin
      $display("FAIL %s timeout: no done_o within %0d cycles (op=%0d a=%h b=%h)", name, lat, op, a, b);
    end else if (res !== exp_res) begin
      $display("FAIL %s result: op=%0d a=%h b=%h got %h expected %h", name, op, a, b, res, exp_res);
    end else n_pass++;
    n_total++;
    if (!to && lat != exp_lat) begin
      $display("FAIL %s latency: op=%0d got %0d expected %0d", name, op, lat, exp_lat);
    end else if (!to) n_pass++;
    else $display("FAIL %s latency: timed out", name);
  endtask

  task automatic test_reset();
    rst          = 1'b1;
    u_if.start_i = 1'b0;
    u_if.kill_i  = 1'b0;
    u_if.op_i    = OP_ADD;
    u_if.a_i     = '0;
    u_if.b_i     = '0;
    #2;
    n_total++;
    if ({u_if.ready_o, u_if.done_o, u_if.result_o} !== {1'b1, 1'b0, 32'h0}) begin
      $display("FAIL reset: ready=%b done=%b result=%h expected ready=1 done=0 result=0",
               u_if.ready_o, u_if.done_o, u_if.result_o);
    end else n_pass++;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_total++;
    if (u_if.ready_o !== 1'b1) $display("FAIL ready_after_reset: got %b expected 1", u_if.ready_o);
    else n_pass++;
  endtask

  task automatic test_directed();
    check_op("div_7_m2",     OP_DIV,    32'd7,          32'hFFFF_FFFE);
    check_op("rem_7_m2",     OP_REM,    32'd7,          32'hFFFF_FFFE);
    check_op("divu_by0",     OP_DIVU,   32'h1234,       32'h0);
    check_op("remu_by0",     OP_REMU,   32'h1234,       32'h0);
    check_op("div_ovf",      OP_DIV,    32'h8000_0000,  32'hFFFF_FFFF);
    check_op("rem_ovf",      OP_REM,    32'h8000_0000,  32'hFFFF_FFFF);
    check_op("mulh_min",     OP_MULH,   32'h8000_0000,  32'h8000_0000);
    check_op("mulhu_ones",   OP_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF);
    check_op("mulhsu_ones",  OP_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF);
    check_op("mul_ones",     OP_MUL,    32'hFFFF_FFFF,  32'hFFFF_FFFF);
    check_op("divu_big",     OP_DIVU,   32'hFFFF_FFFF,  32'h8000_0001);
    check_op("remu_big",     OP_REMU,   32'hFFFF_FFFF,  32'h8000_0001);
  endtask

  task automatic test_random();
    for (int i = 0; i < 48; i++) begin
      logic [4:0] op;
      op = 5'(14 + $urandom_range(0, 7));
      check_op("random", op, pick_operand(), pick_operand());
    end
  endtask

  task automatic test_back_to_back();
    check_op("b2b_first", OP_MULHU, 32'h1234_5678, 32'h9ABC_DEF0);
    @(negedge clk);
    n_total++;
    if (u_if.ready_o !== 1'b1) $display("FAIL b2b_ready: got %b expected 1", u_if.ready_o);
    else n_pass++;
    check_op("b2b_second", OP_REM, 32'hFFFF_FF9C, 32'd7);
  endtask

  task automatic test_kill();
    logic [31:0] prev;
    int          dones;
    prev = u_if.result_o;
    u_if.start_i = 1'b1;
    u_if.op_i    = OP_DIV;
    u_if.a_i     = 32'd1000;
    u_if.b_i     = 32'd3;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      u_if.start_i = 1'b0;
    end
    u_if.kill_i = 1'b1;
    @(negedge clk);
    n_total++;
    if ({u_if.ready_o, u_if.done_o, u_if.result_o} !== {1'b1, 1'b0, prev}) begin
      $display("FAIL kill_calc: ready=%b done=%b result=%h expected ready=1 done=0 result=%h",
               u_if.ready_o, u_if.done_o, u_if.result_o, prev);
    end else n_pass++;
    u_if.kill_i = 1'b0;
    dones = 0;
    repeat (40) begin
      @(negedge clk);
      if (u_if.done_o === 1'b1) dones++;
    end
    n_total++;
    if (dones != 0) $display("FAIL kill_no_done: got %0d done pulses expected 0", dones);
    else n_pass++;

    // Kill while in DONE suppresses the pulse.
    u_if.start_i = 1'b1;
    u_if.op_i    = OP_DIVU;
    u_if.a_i     = 32'd9;
    u_if.b_i     = 32'd0;
    @(posedge clk);
    #1;
    u_if.start_i = 1'b0;
    u_if.kill_i  = 1'b1;
    @(negedge clk);
    n_total++;
    if ({u_if.ready_o, u_if.done_o} !== 2'b00) begin
      $display("FAIL kill_done: ready=%b done=%b expected ready=0 done=0", u_if.ready_o, u_if.done_o);
    end else n_pass++;
    @(negedge clk);
    u_if.kill_i = 1'b0;
    n_total++;
    if (u_if.ready_o !== 1'b1) $display("FAIL kill_done_idle: ready got %b expected 1", u_if.ready_o);
    else n_pass++;
  endtask

  task automatic test_no_accept();
    int dones;
    // start with kill in IDLE
    u_if.start_i = 1'b1;
    u_if.kill_i  = 1'b1;
    u_if.op_i    = OP_DIVU;
    u_if.a_i     = 32'd5;
    u_if.b_i     = 32'd0;
    @(negedge clk);
    u_if.start_i = 1'b0;
    u_if.kill_i  = 1'b0;
    n_total++;
    if ({u_if.ready_o, u_if.done_o} !== 2'b10) begin
      $display("FAIL start_kill: ready=%b done=%b expected ready=1 done=0", u_if.ready_o, u_if.done_o);
    end else n_pass++;
    // illegal op
    u_if.start_i = 1'b1;
    u_if.op_i    = OP_ADD;
    u_if.a_i     = 32'd5;
    u_if.b_i     = 32'd0;
    dones = 0;
    @(negedge clk);
    u_if.start_i = 1'b0;
    n_total++;
    if (u_if.ready_o !== 1'b1) $display("FAIL illegal_ready: got %b expected 1", u_if.ready_o);
    else n_pass++;
    repeat (40) begin
      if (u_if.done_o === 1'b1) dones++;
      @(negedge clk);
    end
    n_total++;
    if (dones != 0) $display("FAIL illegal_no_done: got %0d done pulses expected 0", dones);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    u_if.start_i = 1'b1;
    u_if.op_i    = OP_DIV;
    u_if.a_i     = 32'd7;
    u_if.b_i     = 32'hFFFF_FFFE;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      u_if.start_i = 1'b0;
    end
    rst = 1'b1;
    #1;
    n_total++;
    if ({u_if.ready_o, u_if.done_o, u_if.result_o} !== {1'b1, 1'b0, 32'h0}) begin
      $display("FAIL reset_mid: ready=%b done=%b result=%h expected ready=1 done=0 result=0",
               u_if.ready_o, u_if.done_o, u_if.result_o);
    end else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    check_op("divu_after_rst", OP_DIVU, 32'd100, 32'd7);
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_kill();
    test_no_accept();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/muldiv_seq.md
# muldiv_seq

Multi-cycle sequencer for the RV32M operations (ALU_MUL through ALU_REMU of `alu_ops_e`). It sits beside the single-cycle ALU in the execute stage. Execute hands it M-extension ops through a start/ready handshake and stalls on `ready_o`/`done_o`. It runs a 32-iteration shift-add multiply or restoring divide on operand magnitudes, applies sign fix-up, and returns one registered 32-bit result.

## Interface
- `XLEN`, 32: operand and result width; only 32 is supported.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `start_i` input 1: request; accepted when `ready_o && start_i && !kill_i`.
- `op_i` input 5: `alu_ops_e` code, sampled at accept.
- `a_i` input 32: rs1 operand (multiplicand / dividend), sampled at accept.
- `b_i` input 32: rs2 operand (multiplier / divisor), sampled at accept.
- `kill_i` input 1: pipeline flush; aborts any in-flight operation.
- `ready_o` output 1: high only in IDLE.
- `done_o` output 1: one-cycle pulse; `result_o` is valid in that cycle.
- `result_o` output 32: last result, held until the next `done_o`.

## Operation
- **States:**
  - IDLE: accepts requests.
  - CALC: 32 iteration cycles.
  - FIX: sign fix-up and result register.
  - DONE: `done_o` = 1.
- **Accepted ops:** only `op_i` codes 5'b01110–5'b10101 are accepted. A start with any other code is ignored; the block stays in IDLE and produces no `done_o`.
- **Accept edge (IDLE → CALC):**
  - Latch `op_i`.
  - Latch |a| and |b|. An operand is treated as signed when: MULH, DIV and REM treat both operands as signed; MULHSU treats only a as signed; MUL and all unsigned ops treat neither as signed.
  - Latch the result sign:
    - MUL*: sign(a) XOR sign(b).
    - DIV: sign(a) XOR sign(b).
    - REM: sign(a).
  - Clear the 6-bit iteration counter.
- **Multiply iteration:** 64-bit accumulator.
  - If the LSB of the multiplier shift register is 1, add the multiplicand into the upper half.
  - Shift right by one.
- **Divide iteration (restoring):**
  - Shift remainder:quotient left by one.
  - Trial-subtract |b| from the remainder in a 33-bit difference.
  - If non-negative, keep the difference and set the quotient LSB.
- **CALC exit:** after iteration 31 (counter = 31) → FIX.
- **FIX:**
  - Negate the 64-bit product, or the quotient/remainder, if the latched sign is set.
  - Select the result:
    - MUL: low 32 bits.
    - MULH, MULHSU, MULHU: high 32 bits.
    - DIV, DIVU: quotient.
    - REM, REMU: remainder.
  - Register into `result_o`; → DONE.
- **Special cases (decided at the accept edge, IDLE → DONE directly, no CALC):**
  - Divide by zero, DIV or DIVU: quotient = 32'hFFFF_FFFF.
  - Divide by zero, REM or REMU: remainder = a.
  - Signed overflow (a = 32'h8000_0000, b = 32'hFFFF_FFFF): DIV → 32'h8000_0000; REM → 0.
- **DONE:** `done_o` = 1 for exactly one cycle, then → IDLE unconditionally.
- **kill_i:**
  - In CALC or FIX: → IDLE on the next edge. No `done_o`; `result_o` is unchanged.
  - In DONE: suppresses `done_o` combinationally and → IDLE.
  - In IDLE: blocks acceptance in that cycle.

## Timing
- **Reset (asynchronous):**
  - State = IDLE, `result_o` = 0, `done_o` = 0, counter = 0.
  - `ready_o` = 1 while reset is asserted and after release.
- **Normal latency:** accept at edge E0. Iterations occur at E1–E32, FIX at E33, DONE is visible in the cycle after E33. `done_o` therefore rises 34 cycles after the accept cycle.
- **Special-case latency:** `done_o` is visible in the cycle immediately after the accept edge.
- **ready_o:** low from the cycle after accept through the DONE cycle inclusive. The earliest back-to-back accept is the cycle after DONE.
- **Operand sampling:** inputs are sampled only at accept; changes to `a_i`/`b_i`/`op_i` during CALC have no effect.
- **Reset mid-operation:** everything returns immediately (asynchronously) to the reset values; the partial result is discarded.
- **Width:** all arithmetic is modulo 2^32 on outputs. The 2's-complement magnitude of 32'h8000_0000 is 2^31 and uses the unsigned path.

## Test plan
- **Signed divide:** DIV a=7, b=-2 → `result_o` 32'hFFFF_FFFD, `done_o` 34 cycles after accept. REM with the same operands → 32'h0000_0001.
- **Divide by zero:** DIVU a=32'h1234, b=0 → 32'hFFFF_FFFF, `done_o` 1 cycle after accept. REMU with the same operands → 32'h0000_1234.
- **Signed overflow:** DIV 32'h8000_0000 / 32'hFFFF_FFFF → 32'h8000_0000; REM → 0; both with 1-cycle latency.
- **Multiply variants:**
  - MULH 32'h8000_0000 × 32'h8000_0000 → 32'h4000_0000.
  - MULHU 32'hFFFF_FFFF × 32'hFFFF_FFFF → 32'hFFFF_FFFE.
  - MULHSU 32'hFFFF_FFFF × 32'hFFFF_FFFF → 32'hFFFF_FFFF.
  - MUL 32'hFFFF_FFFF × 32'hFFFF_FFFF → 32'h0000_0001.
- **Kill and illegal op:**
  - Assert `kill_i` on iteration 10 → no `done_o`, `ready_o` = 1 the next cycle, `result_o` unchanged.
  - `start_i` with `kill_i` in the same IDLE cycle → not accepted.
  - `start_i` with `op_i` = ALU_ADD → ignored.
- **Reset mid-operation:** assert `rst` mid-CALC, asynchronously between edges → `result_o` = 0, `done_o` = 0, `ready_o` = 1 before the next edge. A new DIVU 100/7 after release → 14.
